// File: rtl/dense1_ctrl.sv
// dense1_ctrl: frame sequencer for the dense1 serializer (load pulse, beat count, ack wait, one queued request).
// Optional watchdog built only when DENSE1_CTRL_WATCHDOG_EN is defined; otherwise err_timeout is tied to 0.
module dense1_ctrl #(
   parameter int N_OUT       = 120,
   parameter int CNT_W       = 7,
   parameter int FCNT_W      = 16,
   parameter int TIMEOUT_CYC = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ser_ena,
   input  logic              ser_frame_start,
   input  logic              ser_valid,
   input  logic              ser_frame_end,
   input  logic              ds_ack,
   output logic              busy,
   output logic              pending,
   output logic              done,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              err_len,
   output logic              err_overrun,
   output logic              err_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] N_OUT_C = CNT_W'(N_OUT);

   state_e              state_q, state_d;
   logic                pending_q, pending_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [FCNT_W-1:0]   frame_cnt_q;
   logic                ser_ena_q, busy_q, done_q;
   logic                err_len_q, err_overrun_q;
   logic                len_bad, overrun;

   // The serializer's frame_start strobe is informational only.
   logic unused_frame_start;
   assign unused_frame_start = ser_frame_start;

`ifdef DENSE1_CTRL_WATCHDOG_EN
   localparam int             WD_W     = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            wd_active, timeout, err_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      pending_d  = pending_q;
      beat_cnt_d = beat_cnt_q;
      len_bad    = 1'b0;
      overrun    = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD:   state_d = S_STREAM;
         S_STREAM: begin
            if ((ser_valid || ser_frame_end) && beat_cnt_q != CNT_MAX)
               beat_cnt_d = beat_cnt_q + 1'b1;
            // The frame_end beat is already folded into beat_cnt_d; an ack in the same cycle skips DRAIN.
            if (ser_frame_end) begin
               len_bad = (beat_cnt_d != N_OUT_C);
               state_d = ds_ack ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN:  if (ds_ack) state_d = S_DONE;
         S_DONE: begin
            pending_d = 1'b0;
            state_d   = (pending_q || start) ? S_LOAD : S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase

      // A start in DONE with nothing queued is consumed directly by the DONE->LOAD decision above.
      if (start && state_q != S_IDLE) begin
         if (pending_q)
            overrun = 1'b1;
         else if (state_q != S_DONE)
            pending_d = 1'b1;
      end

`ifdef DENSE1_CTRL_WATCHDOG_EN
      wd_active = (state_q == S_STREAM) || (state_q == S_DRAIN);
      timeout   = 1'b0;
      wd_cnt_d  = wd_cnt_q + 1'b1;
      if (wd_active && !ser_valid && !ds_ack && state_d == state_q && wd_cnt_q == WD_LIMIT) begin
         timeout   = 1'b1;
         state_d   = S_IDLE;
         pending_d = 1'b0;
      end
      if (!wd_active || ser_valid || ds_ack || state_d != state_q)
         wd_cnt_d = '0;
`endif

      if (state_d == S_LOAD)
         beat_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pending_q     <= 1'b0;
         beat_cnt_q    <= '0;
         frame_cnt_q   <= '0;
         ser_ena_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_len_q     <= 1'b0;
         err_overrun_q <= 1'b0;
`ifdef DENSE1_CTRL_WATCHDOG_EN
         wd_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state_q       <= state_d;
         pending_q     <= pending_d;
         beat_cnt_q    <= beat_cnt_d;
         ser_ena_q     <= (state_d == S_LOAD);
         busy_q        <= (state_d != S_IDLE);
         done_q        <= (state_d == S_DONE);
         if (state_d == S_DONE)
            frame_cnt_q <= frame_cnt_q + 1'b1;
         err_len_q     <= err_len_q | len_bad;
         err_overrun_q <= err_overrun_q | overrun;
`ifdef DENSE1_CTRL_WATCHDOG_EN
         wd_cnt_q      <= wd_cnt_d;
         err_timeout_q <= err_timeout_q | timeout;
`endif
      end
   end

   assign ser_ena     = ser_ena_q;
   assign busy        = busy_q;
   assign pending     = pending_q;
   assign done        = done_q;
   assign beat_cnt    = beat_cnt_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_len     = err_len_q;
   assign err_overrun = err_overrun_q;
`ifdef DENSE1_CTRL_WATCHDOG_EN
   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule
